// File: rtl/mir_sequencer.sv
// Microinstruction sequencer: decodes a format-1 opcode and steps IDLE/EXEC/MEM/VGA/DONE,
// driving registered ALU, shifter, memory and VGA controls. MIR_TIMEOUT_EN adds a MEM-wait abort.
module mir_sequencer #(
  parameter int OPCODE_W    = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                mem_ack,
  input  logic                vga_busy,
  output logic [3:0]          aluc,
  output logic [2:0]          sh,
  output logic                read,
  output logic                write,
  output logic                flip,
  output logic                print,
  output logic                done,
  output logic                illegal,
  output logic                timeout
);

  // Handshake: an opcode transfers on a rising edge where instr_valid and instr_ready
  // are both high; instr_ready is high only in IDLE, so instr_valid elsewhere is ignored.

  typedef enum logic [2:0] {IDLE, EXEC, MEM, VGA, DONE} state_t;
  typedef enum logic [2:0] {K_EXEC, K_LDR, K_STR, K_VGP, K_VGF, K_ILL} kind_t;

  state_t              state;
  logic [OPCODE_W-1:0] op_q;

  function automatic kind_t kind_of(input logic [OPCODE_W-1:0] op);
    kind_t k;
    k = K_ILL;
    case (op)
      OPCODE_W'(6):  k = K_STR;
      OPCODE_W'(7):  k = K_LDR;
      OPCODE_W'(11): k = K_VGP;
      OPCODE_W'(12): k = K_VGF;
      OPCODE_W'(0), OPCODE_W'(1), OPCODE_W'(2), OPCODE_W'(3), OPCODE_W'(4),
      OPCODE_W'(5), OPCODE_W'(8), OPCODE_W'(9), OPCODE_W'(10), OPCODE_W'(13):
        k = K_EXEC;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // {aluc, sh} for the EXEC cycle; NOP, RET and undecoded opcodes keep idle values.
  function automatic logic [6:0] alu_code(input logic [OPCODE_W-1:0] op);
    logic [6:0] c;
    c = 7'h7F;
    case (op)
      OPCODE_W'(1):  c = {4'h6, 3'd0};
      OPCODE_W'(2):  c = {4'h5, 3'd0};
      OPCODE_W'(3):  c = {4'h4, 3'd0};
      OPCODE_W'(4):  c = {4'h1, 3'd0};
      OPCODE_W'(5):  c = {4'h3, 3'd0};
      OPCODE_W'(13): c = {4'h7, 3'd0};
      OPCODE_W'(8):  c = {4'hB, 3'd7};
      OPCODE_W'(9):  c = {4'hC, 3'd7};
      default:       c = 7'h7F;
    endcase
    return c;
  endfunction

`ifdef MIR_TIMEOUT_EN
  logic [7:0] cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      instr_ready <= 1'b1;
      aluc        <= 4'hF;
      sh          <= 3'h7;
      read        <= 1'b0;
      write       <= 1'b0;
      flip        <= 1'b0;
      print       <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
`ifdef MIR_TIMEOUT_EN
      timeout     <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q        <= opcode;
            instr_ready <= 1'b0;
`ifdef MIR_TIMEOUT_EN
            cnt         <= '0;
`endif
            case (kind_of(opcode))
              K_LDR:        begin state <= MEM; read  <= 1'b1; end
              K_STR:        begin state <= MEM; write <= 1'b1; end
              K_VGP, K_VGF: state <= VGA;
              default: begin
                state      <= EXEC;
                {aluc, sh} <= alu_code(opcode);
              end
            endcase
          end
        end
        EXEC: begin
          state   <= DONE;
          aluc    <= 4'hF;
          sh      <= 3'h7;
          done    <= 1'b1;
          illegal <= (kind_of(op_q) == K_ILL);
        end
        MEM: begin
          if (mem_ack) begin
            state <= DONE;
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
          end
`ifdef MIR_TIMEOUT_EN
          // cnt holds the number of MEM cycles already completed without an ack.
          else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
            state   <= DONE;
            read    <= 1'b0;
            write   <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        VGA: begin
          // A strobe lasts exactly one cycle; it follows an edge that saw vga_busy low.
          if (print || flip) begin
            state <= DONE;
            print <= 1'b0;
            flip  <= 1'b0;
            done  <= 1'b1;
          end else if (!vga_busy) begin
            if (kind_of(op_q) == K_VGP) print <= 1'b1;
            else                        flip  <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
`ifdef MIR_TIMEOUT_EN
          timeout     <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mir_sequencer.sv
// Directed bench for mir_sequencer: hand-computed output vectors sampled on the falling edge.
module tb_mir_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [9:0] opcode;
  logic       instr_ready;
  logic       mem_ack;
  logic       vga_busy;
  logic [3:0] aluc;
  logic [2:0] sh;
  logic       read, write, flip, print, done, illegal, timeout;

  int n_vec = 0;
  int n_err = 0;

  // outs = {instr_ready, aluc, sh, read, write, flip, print, done, illegal, timeout}
  logic [14:0] outs;
  assign outs = {instr_ready, aluc, sh, read, write, flip, print, done, illegal, timeout};

  localparam logic [14:0] IDLE_V = {1'b1, 4'hF, 3'h7, 7'b0};
  localparam logic [3:0]  S_RD = 4'b1000, S_WR = 4'b0100, S_FL = 4'b0010, S_PR = 4'b0001;

  logic [14:0] exp_q[$];

  mir_sequencer #(.OPCODE_W(10), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .vga_busy(vga_busy),
    .aluc(aluc), .sh(sh), .read(read), .write(write), .flip(flip), .print(print),
    .done(done), .illegal(illegal), .timeout(timeout)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic logic [14:0] busy_v(input logic [3:0] a, input logic [2:0] s,
                                         input logic [3:0] stb);
    return {1'b0, a, s, stb, 3'b000};
  endfunction

  function automatic logic [14:0] done_v(input logic ill, input logic to);
    return {1'b0, 4'hF, 3'h7, 4'b0000, 1'b1, ill, to};
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one handshake, returns #1 after the accepting edge with junk on opcode
  task automatic handshake(input logic [9:0] op);
    @(negedge clk);
    instr_valid = 1'b1;
    opcode      = op;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    opcode      = 10'($urandom_range(0, 1023));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(tag, outs, exp_q.pop_front());
    end
  endtask

  logic [9:0] ex_op  [13] = '{10'h001, 10'h002, 10'h004, 10'h005, 10'h00D, 10'h008,
                              10'h009, 10'h000, 10'h00A, 10'h3FF, 10'h00E, 10'h203, 10'h003};
  logic [3:0] ex_alu [13] = '{4'h6, 4'h5, 4'h1, 4'h3, 4'h7, 4'hB,
                              4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h4};
  logic [2:0] ex_sh  [13] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7,
                              3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
  logic       ex_ill [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; mem_ack = 1'b0; vga_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", outs, IDLE_V);

    // handshake on the very first edge after reset release: ADD
    instr_valid = 1'b1; opcode = 10'h003; rst_n = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0; opcode = 10'h3FF;
    exp_q.push_back(busy_v(4'h4, 3'd0, 4'b0));
    exp_q.push_back(done_v(1'b0, 1'b0));
    exp_q.push_back(IDLE_V);
    drain("add_first_edge");

    // EXEC-path opcodes, including undecoded ones
    for (int i = 0; i < 13; i++) begin
      handshake(ex_op[i]);
      exp_q.push_back(busy_v(ex_alu[i], ex_sh[i], 4'b0));
      exp_q.push_back(done_v(ex_ill[i], 1'b0));
      exp_q.push_back(IDLE_V);
      drain($sformatf("exec_%03h", ex_op[i]));
    end

    // LDR: ack low for 3 MEM cycles, high on the 4th
    handshake(10'h007);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ldr_read", outs, busy_v(4'hF, 3'h7, S_RD));
      if (i == 3) mem_ack = 1'b1;
    end
    @(posedge clk); #1; mem_ack = 1'b0;
    exp_q.push_back(done_v(1'b0, 1'b0));
    exp_q.push_back(IDLE_V);
    drain("ldr_end");

    // STR: ack already high in IDLE is ignored, then acks in the first MEM cycle
    mem_ack = 1'b1;
    @(negedge clk);
    check("ack_ignored_idle", outs, IDLE_V);
    handshake(10'h006);
    @(negedge clk);
    check("str_one_cycle", outs, busy_v(4'hF, 3'h7, S_WR));
    @(negedge clk);
    check("str_done", outs, done_v(1'b0, 1'b0));
    mem_ack = 1'b0;
    @(negedge clk);
    check("str_idle", outs, IDLE_V);

    // VGF: busy seen high on the first VGA edge, low on the second
    vga_busy = 1'b1;
    handshake(10'h00C);
    @(negedge clk);
    check("vgf_wait1", outs, busy_v(4'hF, 3'h7, 4'b0));
    @(negedge clk);
    check("vgf_wait2", outs, busy_v(4'hF, 3'h7, 4'b0));
    vga_busy = 1'b0;
    exp_q.push_back(busy_v(4'hF, 3'h7, S_FL));
    exp_q.push_back(done_v(1'b0, 1'b0));
    exp_q.push_back(IDLE_V);
    drain("vgf");

    // VGP with busy low throughout
    handshake(10'h00B);
    exp_q.push_back(busy_v(4'hF, 3'h7, 4'b0));
    exp_q.push_back(busy_v(4'hF, 3'h7, S_PR));
    exp_q.push_back(done_v(1'b0, 1'b0));
    exp_q.push_back(IDLE_V);
    drain("vgp");

    // VGP stalled by busy, then reset mid-VGA
    vga_busy = 1'b1;
    handshake(10'h00B);
    for (int i = 0; i < 5; i++) exp_q.push_back(busy_v(4'hF, 3'h7, 4'b0));
    drain("vgp_stall");
    #2 rst_n = 1'b0;
    #1 check("reset_mid_vga", outs, IDLE_V);
    @(negedge clk); rst_n = 1'b1; vga_busy = 1'b0;

    // STR with no ack: timeout abort, or indefinite wait without the feature
    handshake(10'h006);
`ifdef MIR_TIMEOUT_EN
    for (int i = 0; i < 16; i++) exp_q.push_back(busy_v(4'hF, 3'h7, S_WR));
    exp_q.push_back(done_v(1'b0, 1'b1));
    exp_q.push_back(IDLE_V);
    drain("str_timeout");
    handshake(10'h007);
    repeat (2) exp_q.push_back(busy_v(4'hF, 3'h7, S_RD));
    drain("ldr_pre_reset");
`else
    for (int i = 0; i < 24; i++) exp_q.push_back(busy_v(4'hF, 3'h7, S_WR));
    drain("str_wait_forever");
`endif
    // reset mid-MEM drops strobes at once
    #2 rst_n = 1'b0;
    #1 check("reset_mid_mem", outs, IDLE_V);
    @(negedge clk);
    check("reset_held", outs, IDLE_V);
    rst_n = 1'b1;

    // sequencer still works after the abort
    handshake(10'h001);
    exp_q.push_back(busy_v(4'h6, 3'd0, 4'b0));
    exp_q.push_back(done_v(1'b0, 1'b0));
    exp_q.push_back(IDLE_V);
    drain("or_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
